// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Stage-state encoding and per-stage payload structs with bubbles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    // The "_X" (don't-care) encodings are all-zero, so each bubble is a NOP
    // with every write enable deasserted.
    localparam logic [2:0] c_INST_X  = 3'd0;
    localparam logic [3:0] c_ALU_X   = 4'd0;
    localparam logic [1:0] c_SRC_X   = 2'd0;
    localparam logic [2:0] c_JUMP_X  = 3'd0;
    localparam logic [1:0] c_BYTE_X  = 2'd0;

    typedef struct packed {
        logic [2:0]  inst_type;
        logic [7:0]  inst_name;
        logic [3:0]  alu_type;
        logic [1:0]  alu_rs1_sel;
        logic [1:0]  alu_rs2_sel;
        logic [2:0]  jump_type;
        logic        ram_wr_en;
        logic [1:0]  ram_byte;
        logic        reg_wr_en;
        logic [1:0]  reg_src;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] jmp_or_reg_data;
        logic [31:0] pc;
    } idu2exu_t;

    localparam idu2exu_t c_IDU2EXU_BUBBLE = '{
        inst_type:       c_INST_X,
        inst_name:       8'd0,
        alu_type:        c_ALU_X,
        alu_rs1_sel:     c_SRC_X,
        alu_rs2_sel:     c_SRC_X,
        jump_type:       c_JUMP_X,
        ram_wr_en:       1'b0,
        ram_byte:        c_BYTE_X,
        reg_wr_en:       1'b0,
        reg_src:         c_SRC_X,
        rs1_data:        32'd0,
        rs2_data:        32'd0,
        jmp_or_reg_data: 32'd0,
        pc:              32'd0
    };

    typedef struct packed {
        logic        ram_wr_en;
        logic [1:0]  ram_byte;
        logic        reg_wr_en;
        logic [1:0]  reg_src;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc;
    } exu2lsu_t;

    localparam exu2lsu_t c_EXU2LSU_BUBBLE = '{
        ram_wr_en:  1'b0,
        ram_byte:   c_BYTE_X,
        reg_wr_en:  1'b0,
        reg_src:    c_SRC_X,
        alu_result: 32'd0,
        store_data: 32'd0,
        pc:         32'd0
    };

    typedef struct packed {
        logic        reg_wr_en;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [31:0] pc;
    } lsu2wbu_t;

    localparam lsu2wbu_t c_LSU2WBU_BUBBLE = '{
        reg_wr_en: 1'b0,
        rd_addr:   5'd0,
        rd_data:   32'd0,
        pc:        32'd0
    };

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with flush-to-bubble.
//               PIPE_STAGE_SKID_EN adds a skid entry and registered o_pre_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_flush,
    input  logic                  i_pre_valid,
    output logic                  o_pre_ready,
    input  logic [DATA_WIDTH-1:0] i_pre_data,
    output logic                  o_post_valid,
    input  logic                  i_post_ready,
    output logic [DATA_WIDTH-1:0] o_post_data,
    output logic [1:0]            o_occupancy
);
    import pipe_pkg::*;

    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] w_main_nxt;
    logic                  w_in;
    logic                  w_out;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_WIDTH-1:0] r_skid;
    logic [DATA_WIDTH-1:0] w_skid_nxt;
`endif

    assign w_in         = i_pre_valid && o_pre_ready;
    assign w_out        = o_post_valid && i_post_ready;
    assign o_post_valid = (r_state != PIPE_EMPTY);
    assign o_post_data  = r_main;

`ifdef PIPE_STAGE_SKID_EN
    // Decoded straight from the state register: no path from i_post_ready.
    assign o_pre_ready = (r_state != PIPE_TWO);
    assign o_occupancy = {r_state == PIPE_TWO, r_state == PIPE_ONE};
`else
    assign o_pre_ready = (r_state == PIPE_EMPTY) || i_post_ready;
    assign o_occupancy = {1'b0, r_state != PIPE_EMPTY};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
`ifdef PIPE_STAGE_SKID_EN
        w_skid_nxt  = r_skid;
`endif
        if (i_flush) begin
            w_state_nxt = PIPE_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
        end else begin
            case (r_state)
                PIPE_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = PIPE_ONE;
                        w_main_nxt  = i_pre_data;
                    end
                end
                PIPE_ONE: begin
                    if (w_in && w_out) begin
                        w_main_nxt  = i_pre_data;
                    end else if (w_out) begin
                        w_state_nxt = PIPE_EMPTY;
                        w_main_nxt  = BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (w_in) begin
                        w_state_nxt = PIPE_TWO;
                        w_skid_nxt  = i_pre_data;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PIPE_TWO: begin
                    if (w_out) begin
                        w_state_nxt = PIPE_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
`endif
                default: begin
                    w_state_nxt = PIPE_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= PIPE_EMPTY;
            r_main  <= BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            r_skid  <= BUBBLE_VAL;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
`ifdef PIPE_STAGE_SKID_EN
            r_skid  <= w_skid_nxt;
`endif
        end
    end

endmodule

`default_nettype wire
